// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC source encodings and the default reset PC.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   localparam logic [1:0] PCSRC_SEQ = 2'd0;
   localparam logic [1:0] PCSRC_BR  = 2'd1;
   localparam logic [1:0] PCSRC_J   = 2'd2;
   localparam logic [1:0] PCSRC_JR  = 2'd3;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and instruction memory.
interface fetch_pc_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection; shared by the multicycle fetch unit and the single-cycle PC path.
module next_pc_sel
   import cpu_pkg::*;
(
   input  logic [31:0] PC,
   input  logic [31:0] IR,
   input  logic [1:0]  PCSrc,
   input  logic        Branch,
   input  logic        Zero,
   input  logic [31:0] rs_data,
   output logic [31:0] next_pc
);

   logic [31:0] pcPlus4;
   logic [31:0] brTarget;
   logic [31:0] jmpTarget;
   logic [31:0] jrTarget;
   logic        unusedBits;

   assign pcPlus4   = PC + 32'd4;
   assign brTarget  = pcPlus4 + {{14{IR[15]}}, IR[15:0], 2'b00};
   assign jmpTarget = {pcPlus4[31:28], IR[25:0], 2'b00};
   // Misaligned jr targets are silently aligned rather than trapped.
   assign jrTarget  = {rs_data[31:2], 2'b00};

   assign unusedBits = ^{IR[31:26], rs_data[1:0]};

   always_comb begin
      next_pc = pcPlus4;
      case (PCSrc)
         PCSRC_SEQ: next_pc = pcPlus4;
         PCSRC_BR:  next_pc = (Branch && Zero) ? brTarget : pcPlus4;
         PCSRC_J:   next_pc = jmpTarget;
         PCSRC_JR:  next_pc = jrTarget;
         default:   next_pc = pcPlus4;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Multicycle fetch stage: owns PC and IR, fetches from instruction memory and advances the PC
// once downstream reports the current instruction done.
module fetch_pc_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   clk,
   input  logic                   reset,
   fetch_pc_unit_if.master        imem,
   output logic [31:0]            Instruction,
   output logic [5:0]             OpCode,
   output logic [5:0]             Funct,
   output logic [31:0]            PC,
   output logic [31:0]            PC_plus_4,
   output logic                   inst_valid,
   input  logic                   exec_done,
   input  logic                   stall,
   input  logic [1:0]             PCSrc,
   input  logic                   Branch,
   input  logic                   Zero,
   input  logic [31:0]            rs_data
);

   state_t      state;
   logic        fetchReq;
   logic [31:0] nextPc;

   assign imem.imem_req  = fetchReq;
   assign imem.imem_addr = PC;
   assign OpCode         = Instruction[31:26];
   assign Funct          = Instruction[5:0];
   assign PC_plus_4      = PC + 32'd4;

   next_pc_sel u_next_pc_sel (
      .PC      (PC),
      .IR      (Instruction),
      .PCSrc   (PCSrc),
      .Branch  (Branch),
      .Zero    (Zero),
      .rs_data (rs_data),
      .next_pc (nextPc)
   );

   // imem_req and inst_valid are registered alongside the state so nothing downstream
   // sees a combinational path from the memory side.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         PC          <= RESET_PC;
         Instruction <= 32'h0000_0000;
         inst_valid  <= 1'b0;
         fetchReq    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state    <= FETCH;
               fetchReq <= 1'b1;
            end
            FETCH: begin
               if (imem.imem_ready) begin
                  Instruction <= imem.imem_rdata;
                  state       <= EXEC;
                  fetchReq    <= 1'b0;
                  inst_valid  <= 1'b1;
               end
            end
            EXEC: begin
               if (exec_done && !stall) begin
                  PC         <= nextPc;
                  state      <= FETCH;
                  fetchReq   <= 1'b1;
                  inst_valid <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               fetchReq   <= 1'b0;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Multicycle instruction-fetch stage. Holds the PC and the instruction register (IR), and handshakes with instruction memory.
- Presents OpCode/Funct to the control decoder. Consumes the decoder's PCSrc/Branch, the ALU Zero flag and the rs register value to compute the next PC.
- Sits directly upstream of control decode and register read. Downstream signals exec_done when the current instruction has finished.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, equal to PC
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- Instruction  out  32  IR contents
- OpCode  out  6  IR[31:26]
- Funct  out  6  IR[5:0]
- PC  out  32  address of the instruction in IR
- PC_plus_4  out  32  PC + 4, used as the jal/jalr link value
- inst_valid  out  1  IR holds a valid instruction being executed
- exec_done  in  1  downstream finished the current instruction
- stall  in  1  hold the PC update
- PCSrc  in  2  0 seq, 1 beq, 2 j/jal, 3 jr/jalr
- Branch  in  1  instruction is a conditional branch
- Zero  in  1  ALU equality result
- rs_data  in  32  register rs value, jr/jalr target

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, PC=RESET_PC, IR=0, inst_valid=0, imem_req=0.
- FSM states IDLE, FETCH, EXEC:
  - IDLE -> FETCH unconditionally on the next clk edge.
  - FETCH: imem_req=1, imem_addr=PC. When imem_ready=1, capture IR<=imem_rdata and go to EXEC; otherwise remain in FETCH.
  - EXEC: inst_valid=1, imem_req=0. When exec_done=1 and stall=0, load PC<=next_pc and go to FETCH; otherwise hold.
- next_pc (combinational, from registered PC and IR):
  - seq = PC_plus_4
  - br = PC_plus_4 + (sign_ext(IR[15:0]) << 2)
  - jmp = {PC_plus_4[31:28], IR[25:0], 2'b00}
  - jr = {rs_data[31:2], 2'b00}
- Selection:
  - PCSrc=0 -> seq
  - PCSrc=1 -> br if Branch&Zero, else seq
  - PCSrc=2 -> jmp
  - PCSrc=3 -> jr
- Latency: minimum 2 cycles per instruction (1 FETCH with immediate ready, plus 1 EXEC with immediate exec_done).
- Arithmetic is 32-bit modulo; PC 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- Boundary conditions:
  - stall=1 and exec_done=1 in the same cycle: stall wins; PC, IR and state hold.
  - imem_ready outside FETCH: ignored, IR unchanged.
  - exec_done outside EXEC: ignored.
  - PC, IR and inst_valid change only on state transitions as defined above; all outputs are registered or decoded from state and registers only, so there is no combinational path from imem_* to Instruction/OpCode.
  - Reset asserted mid-FETCH or mid-EXEC: immediate return to the reset values; an in-flight memory response is discarded.
  - jr target with rs_data[1:0]!=0: low bits forced to 0, no trap.

Decomposition:
- Shared package cpu_pkg:
  - state enum (IDLE/FETCH/EXEC)
  - PCSrc encodings PCSRC_SEQ=0, PCSRC_BR=1, PCSRC_J=2, PCSRC_JR=3
  - default RESET_PC
- One combinational sub-module, next_pc_sel: inputs PC, IR, PCSrc, Branch, Zero, rs_data; output next_pc. It is shared with the single-cycle PC path.
- The FSM, PC register and IR stay in fetch_pc_unit.

Test Plan:
- Reset release, imem_ready=1 each FETCH cycle, rdata=0x0000_0020 (add), exec_done=1 -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid high every 2nd cycle; OpCode=0, Funct=0x20.
- beq at PC=0x10, IR=0x1000_FFFF, PCSrc=1, Branch=1: Zero=1 -> next PC 0x10; Zero=0 -> next PC 0x14.
- j at PC=0x3000_0000, IR=0x0800_0040, PCSrc=2 -> next PC 0x3000_0100; jr with rs_data=0x0000_1237, PCSrc=3 -> next PC 0x0000_1234.
- imem_ready held low 5 cycles in FETCH -> imem_req stays 1, imem_addr stable, inst_valid=0; ready on cycle 6 -> IR captured, EXEC entered next edge.
- In EXEC, stall=1 with exec_done=1 for 3 cycles -> PC and IR unchanged; stall drops -> PC advances exactly once.
- reset pulsed low mid-FETCH with imem_ready=1 in the same cycle -> IR=0, PC=RESET_PC, state IDLE; first request after release at RESET_PC; PC 0xFFFF_FFFC sequential -> 0x0.
